// File: rtl/id_operand_stage_if.sv
// Operand-stage port bundle: IF/ID instruction, RF read port, EX/MEM/WB bypass sources and the ID/EX register.
// The stage sits on the slave modport; the upstream pipeline/RF side drives through master.
interface id_operand_stage_if;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic [4:0]  ra;
  logic [4:0]  rb;
  logic [31:0] qa;
  logic [31:0] qb;
  logic        ex_we;
  logic        ex_load;
  logic [4:0]  ex_rw;
  logic [31:0] ex_res;
  logic        mem_we;
  logic [4:0]  mem_rw;
  logic [31:0] mem_rd;
  logic        wb_we;
  logic [4:0]  wb_rw;
  logic [31:0] wb_rd;
  logic        ds_hold;
  logic        flush;
  logic        stall_o;
  logic        dx_valid;
  logic [31:0] dx_pc;
  logic [5:0]  dx_op;
  logic [5:0]  dx_funct;
  logic [31:0] dx_a;
  logic [31:0] dx_b;
  logic [31:0] dx_imm;
  logic [4:0]  dx_rw;
  logic        dx_we;
  logic        dx_load;
  logic        dx_store;
  logic [31:0] stall_cnt;

  modport master (
    output if_valid, if_pc, if_instr, qa, qb,
    output ex_we, ex_load, ex_rw, ex_res, mem_we, mem_rw, mem_rd, wb_we, wb_rw, wb_rd,
    output ds_hold, flush,
    input  ra, rb, stall_o,
    input  dx_valid, dx_pc, dx_op, dx_funct, dx_a, dx_b, dx_imm,
    input  dx_rw, dx_we, dx_load, dx_store, stall_cnt
  );

  modport slave (
    input  if_valid, if_pc, if_instr, qa, qb,
    input  ex_we, ex_load, ex_rw, ex_res, mem_we, mem_rw, mem_rd, wb_we, wb_rw, wb_rd,
    input  ds_hold, flush,
    output ra, rb, stall_o,
    output dx_valid, dx_pc, dx_op, dx_funct, dx_a, dx_b, dx_imm,
    output dx_rw, dx_we, dx_load, dx_store, stall_cnt
  );
endinterface

// File: rtl/id_operand_stage.sv
// Decode/operand fetch with EX>MEM>WB bypass; ID/EX register 1 cycle after IF/ID, RF addresses and stall_o combinational.
// Backpressure: ds_hold freezes ID/EX and stalls IF; a load-use hazard stalls IF and inserts one bubble.
module id_operand_stage (
  input logic               clk,
  input logic               clr_n,
  id_operand_stage_if.slave bus
);
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [4:0]  rw;
    logic        we;
    logic        load;
    logic        store;
  } dx_t;

  logic [5:0]  op;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm16;
  logic        use_a, use_b, has_dest, is_load, is_store;
  logic [4:0]  dest;
  logic [31:0] imm_ext;
  logic [31:0] opnd_a, opnd_b;
  logic        hazard;
  dx_t         dec, dx_d, dx_q;
  logic [31:0] cnt_d, cnt_q;

  assign op    = bus.if_instr[31:26];
  assign rs    = bus.if_instr[25:21];
  assign rt    = bus.if_instr[20:16];
  assign rd    = bus.if_instr[15:11];
  assign imm16 = bus.if_instr[15:0];

  assign bus.ra = rs;
  assign bus.rb = rt;

  always_comb begin
    use_a    = 1'b0;
    use_b    = 1'b0;
    has_dest = 1'b0;
    dest     = 5'd0;
    is_load  = 1'b0;
    is_store = 1'b0;
    case (op)
      6'h00: begin use_a = 1'b1; use_b = 1'b1; has_dest = 1'b1; dest = rd; end
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E:
             begin use_a = 1'b1; has_dest = 1'b1; dest = rt; end
      6'h0F: begin has_dest = 1'b1; dest = rt; end
      6'h23: begin use_a = 1'b1; has_dest = 1'b1; dest = rt; is_load = 1'b1; end
      6'h2B: begin use_a = 1'b1; use_b = 1'b1; is_store = 1'b1; end
      6'h04, 6'h05: begin use_a = 1'b1; use_b = 1'b1; end
      6'h03: begin has_dest = 1'b1; dest = 5'd31; end
      default: ;
    endcase
  end

  always_comb begin
    case (op)
      6'h0C, 6'h0D, 6'h0E: imm_ext = {16'h0000, imm16};
      6'h0F:               imm_ext = {imm16, 16'h0000};
      default:             imm_ext = {{16{imm16[15]}}, imm16};
    endcase
  end

  // A load still in EX has no data yet, so it is never a bypass source.
  function automatic logic [31:0] resolve(input logic [4:0] s, input logic [31:0] rf_q);
    if (s == 5'd0)                                     return 32'd0;
    else if (bus.ex_we && !bus.ex_load && bus.ex_rw == s) return bus.ex_res;
    else if (bus.mem_we && bus.mem_rw == s)            return bus.mem_rd;
    else if (bus.wb_we && bus.wb_rw == s)              return bus.wb_rd;
    else                                               return rf_q;
  endfunction

  assign opnd_a = resolve(rs, bus.qa);
  assign opnd_b = resolve(rt, bus.qb);

  assign hazard = bus.if_valid && bus.ex_we && bus.ex_load && (bus.ex_rw != 5'd0) &&
                  ((use_a && bus.ex_rw == rs) || (use_b && bus.ex_rw == rt));

  assign bus.stall_o = clr_n && (bus.ds_hold || (!bus.flush && hazard));

  always_comb begin
    dec.valid = bus.if_valid;
    dec.pc    = bus.if_pc;
    dec.op    = op;
    dec.funct = bus.if_instr[5:0];
    dec.a     = opnd_a;
    dec.b     = opnd_b;
    dec.imm   = imm_ext;
    dec.rw    = has_dest ? dest : 5'd0;
    dec.we    = bus.if_valid && has_dest && (dest != 5'd0);
    dec.load  = bus.if_valid && is_load;
    dec.store = bus.if_valid && is_store;

    dx_d  = dx_q;
    cnt_d = cnt_q;
    if (bus.ds_hold) begin
      dx_d = dx_q;
    end else if (bus.flush) begin
      dx_d = '0;
    end else if (hazard) begin
      dx_d = '0;
      if (cnt_q != 32'hFFFF_FFFF) cnt_d = cnt_q + 32'd1;
    end else begin
      dx_d = dec;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      dx_q  <= '0;
      cnt_q <= '0;
    end else begin
      dx_q  <= dx_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.dx_valid  = dx_q.valid;
  assign bus.dx_pc     = dx_q.pc;
  assign bus.dx_op     = dx_q.op;
  assign bus.dx_funct  = dx_q.funct;
  assign bus.dx_a      = dx_q.a;
  assign bus.dx_b      = dx_q.b;
  assign bus.dx_imm    = dx_q.imm;
  assign bus.dx_rw     = dx_q.rw;
  assign bus.dx_we     = dx_q.we;
  assign bus.dx_load   = dx_q.load;
  assign bus.dx_store  = dx_q.store;
  assign bus.stall_cnt = cnt_q;
endmodule

// File: tb/tb_id_operand_stage.sv
// Scoreboarded bench for id_operand_stage: expected ID/EX contents are queued as each cycle is driven.
module tb_id_operand_stage;
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [4:0]  rw;
    logic        we;
    logic        load;
    logic        store;
    logic [31:0] cnt;
  } tb_dx_t;

  logic   clk;
  logic   clr_n;
  int     checks = 0;
  int     errors = 0;
  tb_dx_t exp_q[$];
  tb_dx_t got, exp_v, prev;

  id_operand_stage_if bus();

  id_operand_stage dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic tb_dx_t mk(input logic v, input logic [31:0] pc, input logic [5:0] op,
                                input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] imm, input logic [4:0] rw, input logic we,
                                input logic ld, input logic st, input logic [31:0] cnt);
    tb_dx_t t;
    t.valid = v; t.pc = pc; t.op = op; t.funct = fn; t.a = a; t.b = b; t.imm = imm;
    t.rw = rw; t.we = we; t.load = ld; t.store = st; t.cnt = cnt;
    return t;
  endfunction

  function automatic tb_dx_t sample();
    tb_dx_t s;
    s.valid = bus.dx_valid; s.pc = bus.dx_pc; s.op = bus.dx_op; s.funct = bus.dx_funct;
    s.a = bus.dx_a; s.b = bus.dx_b; s.imm = bus.dx_imm; s.rw = bus.dx_rw;
    s.we = bus.dx_we; s.load = bus.dx_load; s.store = bus.dx_store; s.cnt = bus.stall_cnt;
    return s;
  endfunction

  task automatic idle();
    bus.if_valid = 1'b0; bus.if_pc = '0; bus.if_instr = '0; bus.qa = '0; bus.qb = '0;
    bus.ex_we = 1'b0; bus.ex_load = 1'b0; bus.ex_rw = '0; bus.ex_res = '0;
    bus.mem_we = 1'b0; bus.mem_rw = '0; bus.mem_rd = '0;
    bus.wb_we = 1'b0; bus.wb_rw = '0; bus.wb_rd = '0;
    bus.ds_hold = 1'b0; bus.flush = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clr_n = 1'b0;
    idle();
    #3;
    got = sample();
    checks++;
    if (got !== '0) begin errors++; $display("FAIL reset_state got=%h exp=0", got); end
    checks++;
    if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", bus.stall_o); end
    tick();
    got = sample();
    checks++;
    if (got !== '0) begin errors++; $display("FAIL reset_held got=%h exp=0", got); end
    #6 clr_n = 1'b1;
  endtask

  task automatic test_forward();
    logic [31:0] pcs [3];
    logic [31:0] exp_a [3];
    pcs = '{32'h100, 32'h104, 32'h108};
    exp_a = '{32'hAAAA, 32'hBBBB, 32'h1111};
    idle();
    bus.if_valid = 1'b1; bus.if_instr = rtype(5'd1, 5'd2, 5'd3, 6'h20);
    bus.qa = 32'h1111; bus.qb = 32'h1111;
    bus.ex_we = 1'b1; bus.ex_rw = 5'd1; bus.ex_res = 32'hAAAA;
    bus.mem_we = 1'b1; bus.mem_rw = 5'd1; bus.mem_rd = 32'hBBBB;
    bus.wb_we = 1'b1; bus.wb_rw = 5'd2; bus.wb_rd = 32'hCCCC;
    #1;
    checks++;
    if ({bus.ra, bus.rb} !== {5'd1, 5'd2}) begin
      errors++; $display("FAIL rf_addr got=%h/%h exp=01/02", bus.ra, bus.rb);
    end
    for (int i = 0; i < 3; i++) begin
      bus.if_pc = pcs[i];
      if (i == 1) bus.ex_we = 1'b0;
      if (i == 2) bus.mem_we = 1'b0;
      exp_q.push_back(mk(1'b1, pcs[i], 6'h00, 6'h20, exp_a[i], 32'hCCCC, 32'h1820, 5'd3,
                         1'b1, 1'b0, 1'b0, 32'd0));
      tick();
      got = sample(); exp_v = exp_q.pop_front();
      checks++;
      if (got !== exp_v) begin errors++; $display("FAIL forward_%0d got=%h exp=%h", i, got, exp_v); end
    end
  endtask

  task automatic test_load_use();
    idle();
    bus.if_valid = 1'b1; bus.if_pc = 32'h200; bus.if_instr = itype(6'h2B, 5'd5, 5'd6, 16'h0004);
    bus.qa = 32'h55; bus.qb = 32'h66;
    bus.ex_we = 1'b1; bus.ex_load = 1'b1; bus.ex_rw = 5'd5; bus.ex_res = 32'hDEAD;
    #1;
    checks++;
    if (bus.stall_o !== 1'b1) begin errors++; $display("FAIL loaduse_stall got=%b exp=1", bus.stall_o); end
    exp_q.push_back(mk(1'b0, '0, '0, '0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 32'd1));
    tick();
    got = sample(); exp_v = exp_q.pop_front();
    checks++;
    if (got !== exp_v) begin errors++; $display("FAIL loaduse_bubble got=%h exp=%h", got, exp_v); end
    bus.ex_we = 1'b0; bus.ex_load = 1'b0; bus.ex_rw = '0;
    bus.mem_we = 1'b1; bus.mem_rw = 5'd5; bus.mem_rd = 32'h1234;
    #1;
    checks++;
    if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL loaduse_release got=%b exp=0", bus.stall_o); end
    exp_q.push_back(mk(1'b1, 32'h200, 6'h2B, 6'h04, 32'h1234, 32'h66, 32'h4, 5'd0,
                       1'b0, 1'b0, 1'b1, 32'd1));
    tick();
    got = sample(); exp_v = exp_q.pop_front();
    checks++;
    if (got !== exp_v) begin errors++; $display("FAIL loaduse_mem_fwd got=%h exp=%h", got, exp_v); end
  endtask

  task automatic test_zero();
    idle();
    bus.if_valid = 1'b1; bus.if_instr = itype(6'h08, 5'd0, 5'd0, 16'hFFFF);
    bus.ex_we = 1'b1; bus.ex_rw = 5'd0; bus.ex_res = 32'd7;
    for (int i = 0; i < 2; i++) begin
      bus.if_pc = 32'h300 + 32'(i * 4);
      bus.ex_load = (i == 1);
      #1;
      checks++;
      if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL zero_stall_%0d got=%b exp=0", i, bus.stall_o); end
      exp_q.push_back(mk(1'b1, 32'h300 + 32'(i * 4), 6'h08, 6'h3F, 32'd0, 32'd0, 32'hFFFF_FFFF,
                         5'd0, 1'b0, 1'b0, 1'b0, 32'd1));
      tick();
      got = sample(); exp_v = exp_q.pop_front();
      checks++;
      if (got !== exp_v) begin errors++; $display("FAIL zero_reg_%0d got=%h exp=%h", i, got, exp_v); end
    end
  endtask

  task automatic test_immediates();
    logic [31:0] instr [3];
    tb_dx_t      e [3];
    instr = '{itype(6'h0D, 5'd1, 5'd2, 16'h8000), itype(6'h0F, 5'd0, 5'd4, 16'h8000),
              itype(6'h0A, 5'd1, 5'd3, 16'h8000)};
    e[0] = mk(1'b1, 32'h400, 6'h0D, 6'h00, 32'h10, 32'h10, 32'h0000_8000, 5'd2, 1'b1, 1'b0, 1'b0, 32'd1);
    e[1] = mk(1'b1, 32'h404, 6'h0F, 6'h00, 32'h0,  32'h10, 32'h8000_0000, 5'd4, 1'b1, 1'b0, 1'b0, 32'd1);
    e[2] = mk(1'b1, 32'h408, 6'h0A, 6'h00, 32'h10, 32'h10, 32'hFFFF_8000, 5'd3, 1'b1, 1'b0, 1'b0, 32'd1);
    idle();
    bus.if_valid = 1'b1; bus.qa = 32'h10; bus.qb = 32'h10;
    for (int i = 0; i < 3; i++) begin
      bus.if_pc = 32'h400 + 32'(i * 4);
      bus.if_instr = instr[i];
      exp_q.push_back(e[i]);
      tick();
      got = sample(); exp_v = exp_q.pop_front();
      checks++;
      if (got !== exp_v) begin errors++; $display("FAIL imm_%0d got=%h exp=%h", i, got, exp_v); end
    end
  endtask

  task automatic test_priority();
    idle();
    bus.if_valid = 1'b1; bus.if_pc = 32'h500; bus.if_instr = rtype(5'd8, 5'd9, 5'd7, 6'h20);
    bus.qa = 32'h80; bus.qb = 32'h90;
    prev = mk(1'b1, 32'h500, 6'h00, 6'h20, 32'h80, 32'h90, 32'h3820, 5'd7, 1'b1, 1'b0, 1'b0, 32'd1);
    exp_q.push_back(prev);
    tick();
    got = sample(); exp_v = exp_q.pop_front();
    checks++;
    if (got !== exp_v) begin errors++; $display("FAIL prio_load got=%h exp=%h", got, exp_v); end
    bus.if_pc = 32'h504;
    bus.ds_hold = 1'b1; bus.flush = 1'b1;
    bus.ex_we = 1'b1; bus.ex_load = 1'b1; bus.ex_rw = 5'd8;
    #1;
    checks++;
    if (bus.stall_o !== 1'b1) begin errors++; $display("FAIL prio_hold_stall got=%b exp=1", bus.stall_o); end
    exp_q.push_back(prev);
    tick();
    got = sample(); exp_v = exp_q.pop_front();
    checks++;
    if (got !== exp_v) begin errors++; $display("FAIL prio_hold got=%h exp=%h", got, exp_v); end
    bus.ds_hold = 1'b0;
    #1;
    checks++;
    if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL prio_flush_stall got=%b exp=0", bus.stall_o); end
    exp_q.push_back(mk(1'b0, '0, '0, '0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 32'd1));
    tick();
    got = sample(); exp_v = exp_q.pop_front();
    checks++;
    if (got !== exp_v) begin errors++; $display("FAIL prio_flush got=%h exp=%h", got, exp_v); end
  endtask

  task automatic test_back_to_back();
    // rt hazard on R-type, non-used rt on addi, rs hazard on addi, then hazard clears
    logic [31:0] instr [4];
    logic [4:0]  exrw  [4];
    logic        stl   [4];
    tb_dx_t      e     [4];
    instr = '{rtype(5'd8, 5'd9, 5'd7, 6'h20), itype(6'h08, 5'd8, 5'd9, 16'h0010),
              itype(6'h08, 5'd8, 5'd9, 16'h0010), itype(6'h08, 5'd8, 5'd9, 16'h0010)};
    exrw = '{5'd9, 5'd9, 5'd8, 5'd0};
    stl  = '{1'b1, 1'b0, 1'b1, 1'b0};
    e[0] = mk(1'b0, '0, '0, '0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 32'd2);
    e[1] = mk(1'b1, 32'h600, 6'h08, 6'h10, 32'h80, 32'h90, 32'h10, 5'd9, 1'b1, 1'b0, 1'b0, 32'd2);
    e[2] = mk(1'b0, '0, '0, '0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 32'd3);
    e[3] = mk(1'b1, 32'h600, 6'h08, 6'h10, 32'h80, 32'h90, 32'h10, 5'd9, 1'b1, 1'b0, 1'b0, 32'd3);
    idle();
    bus.if_valid = 1'b1; bus.if_pc = 32'h600; bus.qa = 32'h80; bus.qb = 32'h90;
    for (int i = 0; i < 4; i++) begin
      bus.if_instr = instr[i];
      bus.ex_we = (exrw[i] != 5'd0); bus.ex_load = 1'b1; bus.ex_rw = exrw[i]; bus.ex_res = 32'hBAD;
      #1;
      checks++;
      if (bus.stall_o !== stl[i]) begin
        errors++; $display("FAIL b2b_stall_%0d got=%b exp=%b", i, bus.stall_o, stl[i]);
      end
      exp_q.push_back(e[i]);
      tick();
      got = sample(); exp_v = exp_q.pop_front();
      checks++;
      if (got !== exp_v) begin errors++; $display("FAIL b2b_%0d got=%h exp=%h", i, got, exp_v); end
    end
  endtask

  task automatic test_reset_mid_stall();
    bus.ex_we = 1'b1; bus.ex_load = 1'b1; bus.ex_rw = 5'd8;
    #1;
    checks++;
    if (bus.stall_o !== 1'b1) begin errors++; $display("FAIL rst_pre_stall got=%b exp=1", bus.stall_o); end
    #1 clr_n = 1'b0;
    #1;
    got = sample();
    checks++;
    if (got !== '0 || bus.stall_o !== 1'b0) begin
      errors++; $display("FAIL rst_async got=%h stall=%b exp=0", got, bus.stall_o);
    end
    idle();
    tick();
    got = sample();
    checks++;
    if (got !== '0) begin errors++; $display("FAIL rst_hold got=%h exp=0", got); end
    #3 clr_n = 1'b1;
    bus.if_valid = 1'b1; bus.if_pc = 32'h700; bus.if_instr = rtype(5'd1, 5'd2, 5'd3, 6'h20);
    bus.qa = 32'h1; bus.qb = 32'h2;
    exp_q.push_back(mk(1'b1, 32'h700, 6'h00, 6'h20, 32'h1, 32'h2, 32'h1820, 5'd3,
                       1'b1, 1'b0, 1'b0, 32'd0));
    tick();
    got = sample(); exp_v = exp_q.pop_front();
    checks++;
    if (got !== exp_v) begin errors++; $display("FAIL rst_release got=%h exp=%h", got, exp_v); end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_load_use();
    test_zero();
    test_immediates();
    test_priority();
    test_back_to_back();
    test_reset_mid_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/id_operand_stage.md
# id_operand_stage

Decode/operand-fetch stage of the 5-stage pipelined CPU, sitting directly upstream of the execute stage and wrapped around the register file's dual read ports. It extracts source/destination registers and immediates from the IF/ID instruction, drives the register-file read addresses, and resolves operands with EX/MEM/WB forwarding. It detects load-use hazards, stalling IF and inserting bubbles, and holds the ID/EX pipeline register. It also keeps a saturating load-use stall counter.

## Interface
- No parameters; all widths fixed (32-bit datapath, 5-bit register index).
- clk  in  1  pipeline clock, all state on rising edge
- clr_n  in  1  asynchronous, active-low reset
- if_valid, if_pc, if_instr  in  1/32/32  IF/ID register contents
- ra, rb  out  5/5  RF read addresses (combinational: instr[25:21], instr[20:16])
- qa, qb  in  32/32  RF read data (RF returns 0 for index 0)
- ex_we, ex_load, ex_rw, ex_res  in  1/1/5/32  instruction currently in EX
- mem_we, mem_rw, mem_rd  in  1/5/32  instruction in MEM
- wb_we, wb_rw, wb_rd  in  1/5/32  RF write port this cycle (RF updates at the edge; WB must be bypassed)
- ds_hold  in  1  EX cannot accept; hold ID/EX
- flush  in  1  taken branch/jump resolved in EX; kill ID instruction
- stall_o  out  1  hold IF/ID and PC this cycle
- dx_valid, dx_pc, dx_op, dx_funct  out  1/32/6/6  ID/EX register
- dx_a, dx_b, dx_imm  out  32/32/32  resolved operands, extended immediate
- dx_rw, dx_we, dx_load, dx_store  out  5/1/1/1  destination and control
- stall_cnt  out  32  load-use bubble count, saturating

## Operation
- Decode by op = instr[31:26]:
  - 0x00 R-type: uses rs, rt; dest rd.
  - 0x08/09/0A/0B/0C/0D/0E: uses rs; dest rt.
  - 0x0F LUI: dest rt.
  - 0x23 LW: uses rs; dest rt; load.
  - 0x2B SW: uses rs, rt; store.
  - 0x04/05 BEQ/BNE: uses rs, rt.
  - 0x02 J: nothing.
  - 0x03 JAL: dest 31.
  - Any other op: no dest, no uses.
- dx_we = has_dest && dest != 0.
- Immediate: 0x0C/0D/0E zero-extend imm16; 0x0F gives {imm16, 16'h0}; all others sign-extend.
- Operand resolution per source index s (same rule for a and b):
  - s == 0 gives 0.
  - Otherwise first match wins: EX (ex_we && !ex_load && ex_rw == s) gives ex_res; MEM gives mem_rd; WB gives wb_rd; else RF (qa/qb).
- Load-use hazard: if_valid && ex_we && ex_load && ex_rw != 0 && ex_rw equals a source the instruction uses.
- Per-cycle priority:
  1. ds_hold: ID/EX unchanged; stall_o = 1; flush ignored.
  2. flush: ID/EX becomes a bubble; stall_o = 0.
  3. Hazard: ID/EX becomes a bubble; stall_o = 1; stall_cnt increments.
  4. Otherwise ID/EX loads the decoded/resolved values; dx_valid = if_valid.
- Bubble = dx_valid, dx_we, dx_load and dx_store all 0; other fields don't-care but driven to 0.
- If !if_valid, the load path yields dx_valid = 0, dx_we = 0 and stall_o = 0.
- stall_cnt saturates at 32'hFFFFFFFF.

## Timing
- ra, rb, stall_o and the forwarding muxes are combinational from the current inputs.
- ID/EX outputs change only on the rising clk edge; latency is 1 cycle, IF/ID to dx_*.
- Load-use costs exactly one bubble: on the next cycle the load is in MEM and is forwarded from MEM.
- clr_n low forces every dx_* output and stall_cnt to 0 immediately, without waiting for clk.
- stall_o is combinational, so it reads 0 while clr_n is low (dx_* zero, !if_valid assumed during reset).
- Release is synchronous to the next edge.
- Reset asserted mid-stall discards the held instruction.

## Test plan
- Forward priority:
  - Stimulus: `add $3,$1,$2` with ex_rw=1 (ex_res=0xAAAA), mem_rw=1 (0xBBBB), wb_rw=2 (0xCCCC), qa=qb=0x1111.
  - Required: dx_a=0xAAAA, dx_b=0xCCCC, dx_rw=3, dx_we=1.
- Load-use:
  - Stimulus: ex_load=1, ex_rw=5; ID holds `sw $6,4($5)`.
  - Required: stall_o=1; next edge gives a bubble and stall_cnt=1.
  - Stimulus: next cycle, ex idle, mem_rw=5, mem_rd=0x1234.
  - Required: dx_a=0x1234, dx_store=1.
- $zero:
  - Stimulus: `addi $0,$0,-1` with ex_rw=0, ex_res=7.
  - Required: dx_a=0, dx_imm=0xFFFFFFFF, dx_we=0.
- Immediates:
  - ori imm 0x8000 gives dx_imm=0x00008000.
  - lui imm 0x8000 gives 0x80000000.
  - slti imm 0x8000 gives 0xFFFF8000.
- Priority:
  - ds_hold and flush together with a hazard: ID/EX unchanged, stall_o=1, stall_cnt unchanged.
  - flush and hazard together: bubble, stall_o=0, stall_cnt unchanged.
- Reset:
  - Stimulus: drop clr_n mid-cycle with stall_cnt=3, dx_valid=1.
  - Required: all outputs 0 immediately; the first edge after release loads normally.
